// File: rtl/reg_disp_scanner.sv
// rtl/reg_disp_scanner.sv - register-file debug reader with 8-digit multiplexed hex display
module reg_disp_scanner #(
  parameter logic [15:0] REFRESH_DIV  = 16'd50000,
  parameter logic [7:0]  DWELL_FRAMES = 8'd200,
  parameter logic [3:0]  SETTLE       = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_en,
  input  logic        step,
  input  logic        load,
  input  logic [4:0]  reg_sel_in,
  input  logic [31:0] disp_dat,
  output logic [4:0]  disp_sel,
  output logic        snap_valid,
  output logic [7:0]  anode,
  output logic [6:0]  seg
);

  typedef enum logic {SELECT, SHOW} state_t;

  state_t      state, state_nx;
  logic [15:0] div_cnt;
  logic [2:0]  digit_idx;
  logic [7:0]  frame_cnt, frame_cnt_nx;
  logic [3:0]  settle_cnt, settle_cnt_nx;
  logic [31:0] snapshot, snapshot_nx;
  logic [4:0]  disp_sel_nx;
  logic        snap_valid_nx;
  logic        term_cnt;
  logic        frame_wrap;
  logic [3:0]  nibble;

  assign term_cnt   = (div_cnt == REFRESH_DIV - 16'd1);
  assign frame_wrap = term_cnt && (digit_idx == 3'd7);
  assign nibble     = snapshot[{digit_idx, 2'b00} +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Free-running digit scan: prescaler then digit index, never paused by the FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= 16'd0;
      digit_idx <= 3'd0;
    end else if (term_cnt) begin
      div_cnt   <= 16'd0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      div_cnt   <= div_cnt + 16'd1;
    end
  end

  // Capture FSM state and the registers it owns
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= SELECT;
      disp_sel   <= 5'd0;
      snapshot   <= 32'd0;
      snap_valid <= 1'b0;
      frame_cnt  <= 8'd0;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nx;
      disp_sel   <= disp_sel_nx;
      snapshot   <= snapshot_nx;
      snap_valid <= snap_valid_nx;
      frame_cnt  <= frame_cnt_nx;
      settle_cnt <= settle_cnt_nx;
    end
  end

  // Next-state: settle then capture; in SHOW, index change beats live refresh
  always_comb begin
    state_nx      = state;
    disp_sel_nx   = disp_sel;
    snapshot_nx   = snapshot;
    snap_valid_nx = snap_valid;
    frame_cnt_nx  = frame_cnt;
    settle_cnt_nx = settle_cnt;
    case (state)
      SELECT: begin
        if (settle_cnt == SETTLE - 4'd1) begin
          snapshot_nx   = disp_dat;
          snap_valid_nx = 1'b1;
          frame_cnt_nx  = 8'd0;
          state_nx      = SHOW;
        end else begin
          settle_cnt_nx = settle_cnt + 4'd1;
        end
      end
      default: begin
        if (load) begin
          disp_sel_nx   = reg_sel_in;
          state_nx      = SELECT;
          settle_cnt_nx = 4'd0;
        end else if (step && !auto_en) begin
          disp_sel_nx   = disp_sel + 5'd1;
          state_nx      = SELECT;
          settle_cnt_nx = 4'd0;
        end else if (auto_en && frame_wrap && (frame_cnt == DWELL_FRAMES - 8'd1)) begin
          disp_sel_nx   = disp_sel + 5'd1;
          state_nx      = SELECT;
          settle_cnt_nx = 4'd0;
        end else if (frame_wrap) begin
          // Live refresh; frame count saturates so a later switch to auto advances at once
          snapshot_nx = disp_dat;
          if (frame_cnt != DWELL_FRAMES - 8'd1) begin
            frame_cnt_nx = frame_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  // Registered display drive, blanked until the first capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode <= 8'hFF;
      seg   <= 7'h7F;
    end else if (snap_valid) begin
      anode <= ~(8'b1 << digit_idx);
      seg   <= hex7(nibble);
    end else begin
      anode <= 8'hFF;
      seg   <= 7'h7F;
    end
  end

endmodule

// File: tb/tb_reg_disp_scanner.sv
// tb/tb_reg_disp_scanner.sv - scoreboard bench for reg_disp_scanner (two SETTLE variants)
module tb_reg_disp_scanner;

  localparam int RD = 4;
  localparam int DW = 2;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [4:0] sel;
    logic       v;
    logic [7:0] an;
    logic [6:0] sg;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        auto_en = 1'b0;
  logic        step = 1'b0;
  logic        load = 1'b0;
  logic [4:0]  reg_sel_in = 5'd0;
  logic [31:0] regfile [32];
  logic [31:0] dat0, dat1;
  logic [4:0]  sel0, sel1;
  logic        val0, val1;
  logic [7:0]  an0, an1;
  logic [6:0]  sg0, sg1;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [4:0]  m_sel [2];
  logic [31:0] m_snap [2];
  logic        m_valid [2];
  logic [7:0]  m_an [2];
  logic [6:0]  m_sg [2];
  logic        m_selecting [2];
  int          m_cap_at [2];
  int          m_frames [2];
  int          cyc;

  always #5 clock = ~clock;

  assign dat0 = regfile[sel0];
  assign dat1 = regfile[sel1];

  reg_disp_scanner #(.REFRESH_DIV(16'd4), .DWELL_FRAMES(8'd2), .SETTLE(4'd1)) dut0 (
    .clock(clock), .reset(reset), .auto_en(auto_en), .step(step), .load(load),
    .reg_sel_in(reg_sel_in), .disp_dat(dat0), .disp_sel(sel0), .snap_valid(val0),
    .anode(an0), .seg(sg0));

  reg_disp_scanner #(.REFRESH_DIV(16'd4), .DWELL_FRAMES(8'd2), .SETTLE(4'd4)) dut1 (
    .clock(clock), .reset(reset), .auto_en(auto_en), .step(step), .load(load),
    .reg_sel_in(reg_sel_in), .disp_dat(dat1), .disp_sel(sel1), .snap_valid(val1),
    .anode(an1), .seg(sg1));

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = 5'd0;
      m_snap[k] = 32'd0;
      m_valid[k] = 1'b0;
      m_an[k] = 8'hFF;
      m_sg[k] = 7'h7F;
      m_selecting[k] = 1'b1;
      m_cap_at[k] = settle_of(k) - 1;
      m_frames[k] = 0;
    end
    cyc = 0;
  endtask

  // Reference: scan position is pure arithmetic on cycles since reset release
  task automatic model_edge();
    int   p;
    int   dig;
    logic wrap;
    exp_t e;
    p = cyc % (8 * RD);
    dig = p / RD;
    wrap = (p == 8 * RD - 1);
    for (int k = 0; k < 2; k++) begin
      if (m_valid[k]) begin
        m_an[k] = ~(8'd1 << dig);
        m_sg[k] = HEX[m_snap[k][4*dig +: 4]];
      end else begin
        m_an[k] = 8'hFF;
        m_sg[k] = 7'h7F;
      end
      if (m_selecting[k]) begin
        if (cyc == m_cap_at[k]) begin
          m_snap[k] = regfile[m_sel[k]];
          m_valid[k] = 1'b1;
          m_frames[k] = 0;
          m_selecting[k] = 1'b0;
        end
      end else if (load || (step && !auto_en) || (auto_en && wrap && m_frames[k] == DW - 1)) begin
        m_sel[k] = load ? reg_sel_in : 5'((m_sel[k] + 1) % 32);
        m_selecting[k] = 1'b1;
        m_cap_at[k] = cyc + settle_of(k);
      end else if (wrap) begin
        m_snap[k] = regfile[m_sel[k]];
        if (m_frames[k] < DW - 1) m_frames[k]++;
      end
      e = '{sel: m_sel[k], v: m_valid[k], an: m_an[k], sg: m_sg[k]};
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    cyc++;
  endtask

  task automatic tick(input logic st, input logic ld, input logic [4:0] rs);
    step = st;
    load = ld;
    reg_sel_in = rs;
    @(posedge clock);
    model_edge();
    #1;
    step = 1'b0;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 5'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    cmp("rst_sel0", sel0, 0);   cmp("rst_sel1", sel1, 0);
    cmp("rst_valid0", val0, 0); cmp("rst_valid1", val1, 0);
    cmp("rst_anode0", an0, 8'hFF); cmp("rst_anode1", an1, 8'hFF);
    cmp("rst_seg0", sg0, 7'h7F);   cmp("rst_seg1", sg1, 7'h7F);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: one expected record per instance per clock, compared on the falling edge
  always @(negedge clock) begin
    if (q0.size() > 0 && q1.size() > 0) begin
      exp_t e0, e1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      cmp($sformatf("sel0@%0d", cyc), sel0, e0.sel);
      cmp($sformatf("valid0@%0d", cyc), val0, e0.v);
      cmp($sformatf("anode0@%0d", cyc), an0, e0.an);
      cmp($sformatf("seg0@%0d", cyc), sg0, e0.sg);
      cmp($sformatf("sel1@%0d", cyc), sel1, e1.sel);
      cmp($sformatf("valid1@%0d", cyc), val1, e1.v);
      cmp($sformatf("anode1@%0d", cyc), an1, e1.an);
      cmp($sformatf("seg1@%0d", cyc), sg1, e1.sg);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000_0000 + 32'(i);
    #2;
    do_reset();
    cmp("pre_cap_anode0", an0, 8'hFF);
    tick(1'b0, 1'b0, 5'd0);
    cmp("first_cap_valid0", val0, 1);
    cmp("first_cap_sel0", sel0, 0);
    idle(40);

    auto_en = 1'b1;
    idle(33 * 64 + 10);

    auto_en = 1'b0;
    tick(1'b0, 1'b1, 5'd3);
    idle(10);
    tick(1'b1, 1'b0, 5'd0);
    cmp("step_r3_to_r4", sel0, 4);
    idle(70);
    cmp("manual_no_advance", sel0, 4);
    tick(1'b0, 1'b1, 5'd31);
    idle(5);
    tick(1'b1, 1'b0, 5'd0);
    cmp("step_wrap_31_0", sel0, 0);
    idle(5);
    tick(1'b1, 1'b1, 5'd9);
    cmp("load_beats_step", sel0, 9);
    idle(5);

    tick(1'b0, 1'b1, 5'd2);
    idle(13);
    regfile[2] = 32'hDEAD_BEEF;
    idle(80);

    tick(1'b0, 1'b1, 5'd10);
    tick(1'b1, 1'b0, 5'd0);
    cmp("select_step_ignored0", sel0, 10);
    cmp("select_step_ignored1", sel1, 10);
    idle(20);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) auto_en = ~auto_en;
      if ($urandom_range(9) == 0) regfile[$urandom_range(31)] = $urandom;
      tick(($urandom_range(19) == 0), ($urandom_range(39) == 0), 5'($urandom_range(31)));
    end

    auto_en = 1'b0;
    tick(1'b0, 1'b1, 5'd7);
    idle(40);
    do_reset();
    idle(60);

    @(negedge clock);
    #1;
    cmp("queue_drained", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_disp_scanner.md
Name: reg_disp_scanner

Overview:
- Reader/initiator for the datapath's register-file debug port. It drives disp_sel, captures the returned disp_dat, and shows the 32-bit value as 8 hex digits on a time-multiplexed seven-segment display.
- It can step through r0..r31 automatically or manually, so register state is visible on the board while the core runs.

Parameters:
- REFRESH_DIV, 16'd50000: clock cycles per digit slot. Legal range 2..65535.
- DWELL_FRAMES, 8'd200: full 8-digit frames shown per register in auto mode. Legal range 1..255.
- SETTLE, 4'd1: cycles disp_sel is held before capture. Legal range 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- auto_en  in  1  1 = auto-advance register index; 0 = manual
- step  in  1  one-cycle pulse (already debounced): advance index by 1 (manual mode only)
- load  in  1  one-cycle pulse: load index from reg_sel_in (either mode)
- reg_sel_in  in  5  index used by load
- disp_dat  in  32  register-file debug read data (combinational from disp_sel)
- disp_sel  out  5  register index driven to the datapath
- snap_valid  out  1  first capture done; display active
- anode  out  8  digit enables, active-low; anode[0] = rightmost digit = nibble [3:0]
- seg  out  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a

Behaviour:
- Reset (async, active-high) sets:
  - disp_sel = 0, snapshot = 0, snap_valid = 0
  - state = SELECT; div_cnt, digit_idx, frame_cnt, settle_cnt = 0
  - anode = 8'hFF, seg = 7'h7F
- Reset asserted mid-operation aborts immediately to these values. The sequence resumes from r0 on deassertion.
- FSM, two states:
  - SELECT: disp_sel is stable. settle_cnt counts 0..SETTLE-1. On the edge where settle_cnt == SETTLE-1: snapshot <= disp_dat, snap_valid <= 1, frame_cnt <= 0, go to SHOW. Latency from index change to snapshot update = SETTLE cycles.
  - SHOW, index changes (each forces SELECT on the next edge, settle_cnt <= 0):
    - load: disp_sel <= reg_sel_in.
    - Manual, step: disp_sel <= disp_sel + 1 (31 wraps to 0).
    - Auto, on a frame-wrap edge with frame_cnt == DWELL_FRAMES-1: disp_sel <= disp_sel + 1 (wraps 31 to 0).
  - SHOW, live refresh: on any other frame-wrap edge (no load, no advance), snapshot <= disp_dat, so the shown value tracks register writes once per frame.
  - Priority within SHOW: load > step > auto advance > live refresh.
  - step is ignored when auto_en = 1.
  - step and load pulses arriving in SELECT are ignored; they are not queued.
- Scan counters (run in both states, never stop after reset):
  - div_cnt counts 0..REFRESH_DIV-1.
  - At terminal count, digit_idx increments mod 8.
  - A frame-wrap edge is a terminal count with digit_idx == 7.
  - frame_cnt increments on each frame-wrap edge in SHOW. It saturates at DWELL_FRAMES-1 when auto_en = 0.
  - Switching auto_en 0 to 1 with frame_cnt saturated advances on the next frame wrap.
- Display outputs, registered (one cycle after digit_idx / snapshot):
  - If snap_valid = 0: anode = 8'hFF, seg = 7'h7F.
  - Else: anode = ~(1 << digit_idx), seg = hex7(snapshot[4*digit_idx +: 4]).
  - During SELECT the previous snapshot stays displayed.
- hex7 encoding (active-low, gfedcba), values 0..F:
  - 0..7: 40 79 24 30 19 12 02 78
  - 8..F: 00 10 08 03 46 21 06 0E

Test Plan:
1. Reset and first capture. Params REFRESH_DIV=4, DWELL_FRAMES=2, SETTLE=1; model returns disp_dat = 32'h1000_0000 + disp_sel. Hold reset 3 cycles, release -> anode=FF and seg=7F before capture; disp_sel=0; snapshot = 32'h1000_0000 after 1 cycle; snap_valid=1; then digit 0 shows seg=40 and digit 7 shows seg=79.
2. Auto sweep. auto_en=1, same params -> disp_sel advances every 64 cycles (2 frames x 8 digits x 4), plus 1 SELECT cycle; 31 -> 0 wrap; snapshot for r5 = 32'h1000_0005, digit 0 seg=12.
3. Manual step and load. auto_en=0; step at r3 -> disp_sel=4, frame_cnt stays saturated, no auto advance; load with reg_sel_in=31, then step -> disp_sel=0. step and load in the same cycle with reg_sel_in=9 -> disp_sel=9.
4. Live refresh. Manual, r2 shown; model changes r2 to 32'hDEAD_BEEF mid-frame -> snapshot updates on the next frame-wrap edge; digits 7..0 show seg 21,06,08,21,03,06,06,0E.
5. Ignored pulse. step issued during SELECT (SETTLE=4) -> no index change; completion still 4 cycles after entering SELECT.
6. Async reset mid-SHOW. Assert reset between clock edges -> disp_sel=0, anode=FF, snap_valid=0 immediately, without waiting for a clock edge.
